// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access/writeback stage.
package mem_stage_pkg;

    localparam int RISC_V_DATA_WIDTH   = 32;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_stage_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus watchdog: counts cycles spent waiting and flags the cycle that reaches the limit.
module mem_timeout_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds completed wait cycles, so the limit-th waiting cycle is the one that expires
    assign expired = enable && (cnt == limit - 8'd1);

endmodule

// File: rtl/mem_stage.sv
// Memory-access/writeback stage: branch resolution, dmem req/gnt/rvalid access, writeback beat.
// Optional MEM_STAGE_ACTIVITY_CNT_EN adds saturating load/store/stall activity counters.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = RISC_V_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic                      alu_zero,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_branch,
    input  logic                      ex_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      branch_taken,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      mem_err
`ifdef MEM_STAGE_ACTIVITY_CNT_EN
    ,
    output logic [31:0]               cnt_loads,
    output logic [31:0]               cnt_stores,
    output logic [31:0]               cnt_stall_cycles
`endif
);

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    mem_stage_state_t state;

    logic accept;
    logic mem_op;
    logic illegal_op;
    logic tmo_clear;
    logic tmo_expired;

    logic [DATA_WIDTH-1:0]     addr_p0;
    logic [DATA_WIDTH-1:0]     wdata_p0;
    logic [REG_ADDR_WIDTH-1:0] rd_p0;
    logic                      reg_write_p0;
    logic                      load_p0;

    assign ex_ready   = (state == IDLE);
    assign accept     = ex_valid && ex_ready;
    assign mem_op     = ex_mem_read || ex_mem_write;
    assign illegal_op = ex_mem_read && ex_mem_write;
    assign tmo_clear  = (accept && mem_op && !illegal_op) || (state == REQ && dmem_gnt);

    // Request channel decoded from state so reset drops it without waiting for a clock
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req && !load_p0;
    assign dmem_addr  = dmem_req ? addr_p0 : '0;
    assign dmem_wdata = dmem_req ? wdata_p0 : '0;

    mem_timeout_ctr u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (state != IDLE),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );

    // ---- capture stage: instruction operands latched on accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0      <= alu_result;
            wdata_p0     <= ex_store_data;
            rd_p0        <= ex_rd;
            reg_write_p0 <= ex_reg_write;
            load_p0      <= ex_mem_read;
        end
    end

    // ---- writeback stage: FSM and registered single-cycle result beat ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            branch_taken <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            branch_taken <= 1'b0;
            mem_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal_op) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            mem_err  <= 1'b1;
                        end else if (mem_op) begin
                            state <= REQ;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_we        <= ex_reg_write && !ex_branch;
                            wb_rd        <= ex_rd;
                            wb_data      <= alu_result;
                            branch_taken <= ex_branch && alu_zero;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (load_p0) begin
                            state <= RESP;
                        end else begin
                            state    <= IDLE;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_p0;
                        end
                    end else if (tmo_expired) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p0;
                        mem_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_we    <= reg_write_p0;
                        wb_rd    <= rd_p0;
                        wb_data  <= dmem_rdata;
                    end else if (tmo_expired) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p0;
                        mem_err  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STAGE_ACTIVITY_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_loads        <= '0;
            cnt_stores       <= '0;
            cnt_stall_cycles <= '0;
        end else begin
            if (accept && ex_mem_read && !ex_mem_write) cnt_loads <= sat_inc(cnt_loads);
            if (accept && ex_mem_write && !ex_mem_read) cnt_stores <= sat_inc(cnt_stores);
            if (ex_valid && !ex_ready) cnt_stall_cycles <= sat_inc(cnt_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a transaction-level latency/result model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW  = RISC_V_DATA_WIDTH;
    localparam int RW  = 5;
    localparam int TMO = MEM_TIMEOUT_DEFAULT;

    logic          clk;
    logic          rst;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_branch;
    logic          ex_reg_write;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_store_data;
    logic          branch_taken;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          wb_valid;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .ex_store_data (ex_store_data),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_ex();
        ex_valid      = 1'($urandom_range(0, 1));
        alu_result    = $urandom;
        alu_zero      = 1'($urandom_range(0, 1));
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_mem_write  = 1'($urandom_range(0, 1));
        ex_branch     = 1'($urandom_range(0, 1));
        ex_reg_write  = 1'($urandom_range(0, 1));
        ex_rd         = RW'($urandom);
        ex_store_data = $urandom;
    endtask

    // One instruction from accept to writeback. gw/rw = wait cycles before gnt/rvalid;
    // a wait of TMO or more means the memory never answers.
    task automatic run_txn(input logic rd_op, input logic wr_op, input logic br, input logic zero,
                           input logic rwr, input logic [RW-1:0] rd, input logic [DW-1:0] res,
                           input logic [DW-1:0] sdata, input logic [DW-1:0] rdata,
                           input int gw, input int rw);
        int   req_lo, req_hi, resp_lo, resp_hi, busy_end;
        bit   tmo, in_req, in_resp, g_now, r_now, at_wb;
        logic e_we, e_err, e_br, e_chk_data;
        logic [DW-1:0] e_data;

        req_lo = 0; req_hi = -1; resp_lo = 0; resp_hi = -1; tmo = 0; busy_end = 0;
        e_we = 1'b0; e_err = 1'b0; e_br = 1'b0; e_chk_data = 1'b0; e_data = '0;

        if (rd_op && wr_op) begin
            e_err = 1'b1;
        end else if (!rd_op && !wr_op) begin
            e_we = rwr && !br; e_br = br && zero; e_data = res; e_chk_data = 1'b1;
        end else begin
            req_lo = 1;
            if (gw >= TMO) begin
                req_hi = TMO; tmo = 1;
            end else begin
                req_hi = gw + 1;
                if (rd_op) begin
                    resp_lo = gw + 2;
                    if (rw >= TMO) begin
                        resp_hi = gw + 1 + TMO; tmo = 1;
                    end else begin
                        resp_hi = gw + 2 + rw;
                    end
                end
            end
            busy_end = (resp_hi >= resp_lo && resp_lo > 0) ? resp_hi : req_hi;
            if (tmo) e_err = 1'b1;
            else if (rd_op) begin
                e_we = rwr; e_data = rdata; e_chk_data = 1'b1;
            end
        end

        ex_valid = 1'b1; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_branch = br;
        alu_zero = zero; ex_reg_write = rwr; ex_rd = rd; alu_result = res; ex_store_data = sdata;
        next_cycle();

        for (int k = 1; k <= busy_end + 1; k++) begin
            in_req  = (k >= req_lo) && (k <= req_hi);
            in_resp = (k >= resp_lo) && (k <= resp_hi);
            g_now   = in_req && (gw < TMO) && (k == gw + 1);
            r_now   = in_resp && (rw < TMO) && (k == gw + 2 + rw);
            at_wb   = (k == busy_end + 1);
            if (k <= busy_end) noise_ex();
            else ex_valid = 1'b0;
            dmem_gnt    = g_now || (in_resp && 1'($urandom_range(0, 1)));
            dmem_rvalid = r_now || (in_req && 1'($urandom_range(0, 1))) || (at_wb && tmo);
            dmem_rdata  = r_now ? rdata : $urandom;

            chk_b("ex_ready", ex_ready, !(k <= busy_end));
            chk_b("dmem_req", dmem_req, in_req);
            if (in_req) begin
                chk_b("dmem_we", dmem_we, wr_op);
                chk_w("dmem_addr", dmem_addr, res);
                if (wr_op) chk_w("dmem_wdata", dmem_wdata, sdata);
            end
            chk_b("wb_valid", wb_valid, at_wb);
            chk_b("mem_err", mem_err, at_wb && e_err);
            chk_b("branch_taken", branch_taken, at_wb && e_br);
            if (at_wb) begin
                chk_b("wb_we", wb_we, e_we);
                chk_w("wb_rd", DW'(wb_rd), DW'(rd));
                if (e_chk_data) chk_w("wb_data", wb_data, e_data);
            end
            if (k <= busy_end) next_cycle();
        end
    endtask

    initial begin
        int kind, gw, rw;
        rst = 1'b1; ex_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_branch = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        ex_store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        next_cycle();
        next_cycle();
        chk_b("rst_ex_ready", ex_ready, 1'b1);
        chk_b("rst_wb_valid", wb_valid, 1'b0);
        chk_b("rst_wb_we", wb_we, 1'b0);
        chk_w("rst_wb_rd", DW'(wb_rd), '0);
        chk_w("rst_wb_data", wb_data, '0);
        chk_b("rst_branch", branch_taken, 1'b0);
        chk_b("rst_mem_err", mem_err, 1'b0);
        chk_b("rst_dmem_req", dmem_req, 1'b0);
        chk_b("rst_dmem_we", dmem_we, 1'b0);
        chk_w("rst_dmem_addr", dmem_addr, '0);
        chk_w("rst_dmem_wdata", dmem_wdata, '0);
        rst = 1'b0;
        next_cycle();

        // ALU op, then branches taken / not taken, back-to-back
        run_txn(0, 0, 0, 0, 1, 5'd5, 32'h0000_0010, '0, '0, 0, 0);
        run_txn(0, 0, 1, 1, 1, 5'd3, 32'h0000_0000, '0, '0, 0, 0);
        run_txn(0, 0, 1, 0, 0, 5'd4, 32'h0000_0001, '0, '0, 0, 0);
        // load: gnt after 2 waits, rvalid after 3 waits
        run_txn(1, 0, 0, 0, 1, 5'd7, 32'h0000_0100, '0, 32'hDEAD_BEEF, 2, 3);
        // store held until gnt
        run_txn(0, 1, 0, 0, 1, 5'd9, 32'h0000_0200, 32'h0000_1234, '0, 4, 0);
        // zero-wait load and store
        run_txn(1, 0, 0, 0, 1, 5'd1, 32'h0000_0104, '0, 32'hCAFE_F00D, 0, 0);
        run_txn(0, 1, 0, 0, 0, 5'd2, 32'h0000_0208, 32'h5555_AAAA, '0, 0, 0);
        // illegal read+write
        run_txn(1, 1, 0, 1, 1, 5'd6, 32'h0000_0300, 32'h1, '0, 0, 0);
        // no grant ever: timeout, late rvalid dropped
        run_txn(1, 0, 0, 0, 1, 5'd8, 32'h0000_0400, '0, 32'h1111_1111, TMO, 0);
        // grant but no response: timeout in RESP
        run_txn(1, 0, 0, 0, 1, 5'd10, 32'h0000_0404, '0, 32'h2222_2222, 1, TMO);
        // grant on the very last allowed cycle
        run_txn(0, 1, 0, 0, 0, 5'd11, 32'h0000_0408, 32'h3333_3333, '0, TMO - 1, 0);

        // reset while waiting for load data
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_branch = 1'b0;
        alu_result = 32'h0000_0500; ex_rd = 5'd12; ex_reg_write = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        next_cycle();
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        chk_b("rstmid_req_in_req", dmem_req, 1'b1);
        next_cycle();
        dmem_gnt = 1'b0;
        chk_b("rstmid_resp_ready", ex_ready, 1'b0);
        chk_b("rstmid_resp_req", dmem_req, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_b("rstmid_ex_ready", ex_ready, 1'b1);
        chk_b("rstmid_dmem_req", dmem_req, 1'b0);
        chk_b("rstmid_wb_valid", wb_valid, 1'b0);
        chk_w("rstmid_wb_data", wb_data, '0);
        chk_b("rstmid_mem_err", mem_err, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_txn(1, 0, 0, 0, 1, 5'd13, 32'h0000_0600, '0, 32'h0BAD_F00D, 1, 1);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            gw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 3);
            rw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 3);
            run_txn(kind inside {[4:5], 8}, kind inside {[6:8]}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), RW'($urandom),
                    $urandom, $urandom, $urandom, gw, rw);
        end
        ex_valid = 1'b0;
        next_cycle();
        chk_b("end_wb_valid", wb_valid, 1'b0);
        chk_b("end_ex_ready", ex_ready, 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
